// File: rtl/timer_ctrl.sv
// Key sequencer for the hh:mm:ss.ms timer: per-key debounce, run/stop/set FSM, adjust pulses and blink.
// Build option: define TIMER_CTRL_AUTOREPEAT_EN to enable auto-repeat of held inc/dec keys in the set states.

module timer_ctrl_key #(
  parameter int DEB_MS = 20
) (
  input  logic clk,
  input  logic rst_N,
  input  logic tick_1ms,
  input  logic key_n,
  output logic deb,
  output logic press
);
  localparam logic [9:0] DEB_T = 10'(DEB_MS);

  logic       sync1_q, sync2_q;
  logic       deb_q, deb_d, deb_dly_q;
  logic [9:0] cnt_q, cnt_d, cnt_inc;

  always_comb begin
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 10'd1;
    // deb_q holds the pressed level; sync2_q is still the raw active-low key
    if (~sync2_q == deb_q) cnt_d = '0;
    else if (tick_1ms) begin
      if (cnt_inc >= DEB_T) begin
        deb_d = ~deb_q;
        cnt_d = '0;
      end else cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= key_n;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      cnt_q     <= cnt_d;
    end
  end

  assign deb   = deb_q;
  assign press = deb_q & ~deb_dly_q;
endmodule

module timer_ctrl #(
  parameter int DEB_MS     = 20,
  parameter int RPT_DLY_MS = 500,
  parameter int RPT_PER_MS = 100,
  parameter int BLINK_MS   = 250
) (
  input  logic       clk,
  input  logic       rst_N,
  input  logic       tick_1ms,
  input  logic [5:0] key_N,
  output logic       enable,
  output logic       mode,
  output logic       softrst_N,
  output logic       flag_incmin,
  output logic       flag_decmin,
  output logic       flag_inchour,
  output logic       flag_dechour,
  output logic [1:0] state,
  output logic       blink
);
  localparam int K_START = 0, K_CLR = 1, K_MODE = 2, K_SEL = 3, K_INC = 4, K_DEC = 5;
  localparam logic [9:0] BLINK_T = 10'(BLINK_MS);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, SET_MIN = 2'b10, SET_HOUR = 2'b11} state_e;

  logic [5:0] key_deb, key_press;

  for (genvar i = 0; i < 6; i++) begin : g_key
    timer_ctrl_key #(.DEB_MS(DEB_MS)) u_key (
      .clk(clk), .rst_N(rst_N), .tick_1ms(tick_1ms),
      .key_n(key_N[i]), .deb(key_deb[i]), .press(key_press[i])
    );
  end

  state_e     state_q, state_d;
  logic       mode_q, mode_d, softrst_q, softrst_d, enable_q, enable_d;
  logic       blink_q, blink_d;
  logic [9:0] bcnt_q, bcnt_d, bcnt_inc;
  logic [3:0] flags_q, flags_d;  // {dechour, inchour, decmin, incmin}
  logic       ctl_ev, inc_ev, dec_ev, rpt_inc, rpt_dec;

  // Control events; mode toggles independently of the priority chain.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q ^ key_press[K_MODE];
    softrst_d = 1'b1;
    ctl_ev    = key_press[K_CLR] | key_press[K_START] | key_press[K_SEL];
    if (key_press[K_CLR]) softrst_d = 1'b0;
    else if (key_press[K_START]) state_d = (state_q == RUN) ? IDLE : RUN;
    else if (key_press[K_SEL]) begin
      case (state_q)
        IDLE, RUN: state_d = SET_MIN;
        SET_MIN:   state_d = SET_HOUR;
        default:   state_d = IDLE;
      endcase
    end
  end

`ifdef TIMER_CTRL_AUTOREPEAT_EN
  localparam logic [9:0] DLY_T = 10'(RPT_DLY_MS);
  localparam logic [9:0] PER_T = 10'(RPT_PER_MS);

  logic [9:0] rcnt_q, rcnt_d, rcnt_inc;
  logic       rrep_q, rrep_d, rpt_fire, held_inc, held_dec, unused_deb;

  assign held_inc   = key_deb[K_INC] & ~key_deb[K_DEC];
  assign held_dec   = key_deb[K_DEC] & ~key_deb[K_INC];
  assign unused_deb = ^key_deb[3:0];

  // rrep_q marks that the initial delay has elapsed and the shorter period applies
  always_comb begin
    rcnt_d   = rcnt_q;
    rrep_d   = rrep_q;
    rpt_fire = 1'b0;
    rcnt_inc = (rcnt_q == '1) ? rcnt_q : rcnt_q + 10'd1;
    if (!(state_q[1] && (held_inc || held_dec) && state_d == state_q)) begin
      rcnt_d = '0;
      rrep_d = 1'b0;
    end else if (tick_1ms) begin
      if (rcnt_inc >= (rrep_q ? PER_T : DLY_T)) begin
        rpt_fire = 1'b1;
        rcnt_d   = '0;
        rrep_d   = 1'b1;
      end else rcnt_d = rcnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      rcnt_q <= '0;
      rrep_q <= 1'b0;
    end else begin
      rcnt_q <= rcnt_d;
      rrep_q <= rrep_d;
    end
  end

  assign rpt_inc = rpt_fire & held_inc;
  assign rpt_dec = rpt_fire & held_dec;
`else
  logic unused_rpt;
  assign unused_rpt = ^{RPT_DLY_MS, RPT_PER_MS, key_deb};
  assign rpt_inc    = 1'b0;
  assign rpt_dec    = 1'b0;
`endif

  always_comb begin
    inc_ev   = key_press[K_INC] | rpt_inc;
    dec_ev   = key_press[K_DEC] | rpt_dec;
    flags_d  = '0;
    if (!ctl_ev && (inc_ev ^ dec_ev)) begin
      case (state_q)
        SET_MIN:  flags_d = {2'b00, dec_ev, inc_ev};
        SET_HOUR: flags_d = {dec_ev, inc_ev, 2'b00};
        default:  flags_d = '0;
      endcase
    end
    // flags force enable so the timer sees the adjust in the same cycle
    enable_d = (state_q == RUN && tick_1ms) || (|flags_d);

    blink_d  = blink_q;
    bcnt_d   = bcnt_q;
    bcnt_inc = (bcnt_q == '1) ? bcnt_q : bcnt_q + 10'd1;
    if (!state_d[1]) begin
      blink_d = 1'b0;
      bcnt_d  = '0;
    end else if (state_d != state_q) begin
      blink_d = 1'b1;
      bcnt_d  = '0;
    end else if (tick_1ms) begin
      if (bcnt_inc >= BLINK_T) begin
        blink_d = ~blink_q;
        bcnt_d  = '0;
      end else bcnt_d = bcnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      softrst_q <= 1'b1;
      enable_q  <= 1'b0;
      flags_q   <= '0;
      blink_q   <= 1'b0;
      bcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      softrst_q <= softrst_d;
      enable_q  <= enable_d;
      flags_q   <= flags_d;
      blink_q   <= blink_d;
      bcnt_q    <= bcnt_d;
    end
  end

  assign state        = state_q;
  assign mode         = mode_q;
  assign softrst_N    = softrst_q;
  assign enable       = enable_q;
  assign blink        = blink_q;
  assign flag_incmin  = flags_q[0];
  assign flag_decmin  = flags_q[1];
  assign flag_inchour = flags_q[2];
  assign flag_dechour = flags_q[3];
endmodule
